// File: rtl/niosii_system_data_format_upsizer.sv
// Avalon-ST upsizer: 1 symbol/beat in, 2 symbols/beat out, with independent per-channel pairing state.
// Optional DATA_FORMAT_UPSIZER_SOP_CHECK_EN adds a sticky out_error for SOP arriving mid-pair.
module niosii_system_data_format_upsizer #(
   parameter int unsigned SYMBOL_WIDTH  = 8,
   parameter int unsigned CHANNEL_WIDTH = 1,
   parameter int unsigned NUM_CHANNELS  = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [SYMBOL_WIDTH-1:0]     in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [CHANNEL_WIDTH-1:0]    in_channel,
   input  logic                        in_startofpacket,
   input  logic                        in_endofpacket,
   output logic [2*SYMBOL_WIDTH-1:0]   out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [CHANNEL_WIDTH-1:0]    out_channel,
   output logic                        out_startofpacket,
   output logic                        out_endofpacket,
   output logic                        out_empty
`ifdef DATA_FORMAT_UPSIZER_SOP_CHECK_EN
   ,
   output logic                        out_error
`endif
);

   localparam int unsigned SW    = SYMBOL_WIDTH;
   localparam int unsigned CW    = CHANNEL_WIDTH;
   localparam int unsigned DEPTH = 1 << CHANNEL_WIDTH;

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] clr_idx_q, clr_idx_d;

   logic          phase_q [DEPTH];
   logic [SW-1:0] held_q  [DEPTH];
   logic          sop_q   [DEPTH];

   logic          rd_phase_c, rd_sop_c, eff_phase_c;
   logic [SW-1:0] rd_held_c;
   logic          beat_c, sop_err_c;
   logic          wr_phase_c, wr_sop_c;
   logic [SW-1:0] wr_held_c;
   logic          emit_c, emit_sop_c, emit_eop_c, emit_empty_c;
   logic [2*SW-1:0] emit_data_c;

   // State register for the post-reset clear walk
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_CLEAR;
         clr_idx_q <= CW'(NUM_CHANNELS - 1);
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      case (state_q)
         ST_CLEAR: begin
            if (clr_idx_q == '0) state_d = ST_RUN;
            else                 clr_idx_d = clr_idx_q - CW'(1);
         end
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_CLEAR;
      endcase
   end

   assign in_ready   = !reset && (state_q == ST_RUN) && (!out_valid || out_ready);
   assign beat_c     = in_valid && in_ready && (32'(in_channel) < NUM_CHANNELS);
   assign rd_phase_c = phase_q[in_channel];
   assign rd_held_c  = held_q[in_channel];
   assign rd_sop_c   = sop_q[in_channel];

`ifdef DATA_FORMAT_UPSIZER_SOP_CHECK_EN
   // A new SOP abandons the half-built pair and restarts the channel at phase 0
   assign sop_err_c   = beat_c && rd_phase_c && in_startofpacket;
   assign eff_phase_c = rd_phase_c && !in_startofpacket;
`else
   assign sop_err_c   = 1'b0;
   assign eff_phase_c = rd_phase_c;
`endif

   // Pairing decision for the accepted beat
   always_comb begin
      wr_phase_c   = 1'b0;
      wr_held_c    = rd_held_c;
      wr_sop_c     = rd_sop_c;
      emit_c       = 1'b0;
      emit_data_c  = '0;
      emit_sop_c   = 1'b0;
      emit_eop_c   = 1'b0;
      emit_empty_c = 1'b0;
      if (beat_c) begin
         if (eff_phase_c) begin
            emit_c      = 1'b1;
            emit_data_c = {rd_held_c, in_data};
            emit_sop_c  = rd_sop_c;
            emit_eop_c  = in_endofpacket;
         end else if (in_endofpacket) begin
            emit_c       = 1'b1;
            emit_data_c  = {in_data, SW'(0)};
            emit_sop_c   = in_startofpacket;
            emit_eop_c   = 1'b1;
            emit_empty_c = 1'b1;
         end else begin
            wr_phase_c = 1'b1;
            wr_held_c  = in_data;
            wr_sop_c   = in_startofpacket;
         end
      end
   end

   // Per-channel store: cleared by the walk, otherwise written by accepted beats
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_q == ST_CLEAR) begin
            phase_q[clr_idx_q] <= 1'b0;
            held_q[clr_idx_q]  <= '0;
            sop_q[clr_idx_q]   <= 1'b0;
         end else if (beat_c) begin
            phase_q[in_channel] <= wr_phase_c;
            held_q[in_channel]  <= wr_held_c;
            sop_q[in_channel]   <= wr_sop_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid         <= 1'b0;
         out_data          <= '0;
         out_channel       <= '0;
         out_startofpacket <= 1'b0;
         out_endofpacket   <= 1'b0;
         out_empty         <= 1'b0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (emit_c) begin
            out_valid         <= 1'b1;
            out_data          <= emit_data_c;
            out_channel       <= in_channel;
            out_startofpacket <= emit_sop_c;
            out_endofpacket   <= emit_eop_c;
            out_empty         <= emit_empty_c;
         end
      end
   end

`ifdef DATA_FORMAT_UPSIZER_SOP_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset)          out_error <= 1'b0;
      else if (sop_err_c) out_error <= 1'b1;
   end
`else
   logic unused_c;
   assign unused_c = sop_err_c;
`endif

endmodule

// File: tb/tb_niosii_system_data_format_upsizer.sv
// Directed-vector and model-checked bench for niosii_system_data_format_upsizer.
module tb_niosii_system_data_format_upsizer;

   localparam int unsigned SW = 8;
   localparam int unsigned CW = 1;

   logic            clk = 1'b0;
   logic            reset;
   logic [SW-1:0]   in_data;
   logic            in_valid;
   logic            in_ready;
   logic [CW-1:0]   in_channel;
   logic            in_startofpacket;
   logic            in_endofpacket;
   logic [2*SW-1:0] out_data;
   logic            out_valid;
   logic            out_ready;
   logic [CW-1:0]   out_channel;
   logic            out_startofpacket;
   logic            out_endofpacket;
   logic            out_empty;
`ifdef DATA_FORMAT_UPSIZER_SOP_CHECK_EN
   logic            out_error;
`endif

   niosii_system_data_format_upsizer #(
      .SYMBOL_WIDTH(SW), .CHANNEL_WIDTH(CW), .NUM_CHANNELS(2)
   ) dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .in_channel(in_channel), .in_startofpacket(in_startofpacket),
      .in_endofpacket(in_endofpacket),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_channel(out_channel), .out_startofpacket(out_startofpacket),
      .out_endofpacket(out_endofpacket), .out_empty(out_empty)
`ifdef DATA_FORMAT_UPSIZER_SOP_CHECK_EN
      , .out_error(out_error)
`endif
   );

   always #5 clk = ~clk;

   // {valid, channel, sop, eop, empty, data}
   logic [20:0] obs;
   assign obs = {out_valid, out_channel, out_startofpacket, out_endofpacket, out_empty, out_data};

   typedef struct {
      logic          v;
      logic [CW-1:0] ch;
      logic [SW-1:0] d;
      logic          sop;
      logic          eop;
      logic [20:0]   exp;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [20:0] beat(input logic [CW-1:0] ch, input logic sop, input logic eop,
                                        input logic empty, input logic [15:0] d);
      return {1'b1, ch, sop, eop, empty, d};
   endfunction

   function automatic vec_t mk(input logic v, input logic [CW-1:0] ch, input logic [SW-1:0] d,
                               input logic sop, input logic eop, input logic [20:0] exp);
      vec_t r;
      r.v = v; r.ch = ch; r.d = d; r.sop = sop; r.eop = eop; r.exp = exp;
      return r;
   endfunction

   task automatic drive(input logic v, input logic [CW-1:0] ch, input logic [SW-1:0] d,
                        input logic sop, input logic eop);
      in_valid = v; in_channel = ch; in_data = d;
      in_startofpacket = sop; in_endofpacket = eop;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      out_ready = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      step();
      step();
      chk("rst_outputs", 32'(obs), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      reset = 1'b0;
      #1;
      chk("clear_rdy_c0", 32'(in_ready), 32'h0);
      step();
      chk("clear_rdy_c1", 32'(in_ready), 32'h0);
      chk("clear_outputs", 32'(obs), 32'h0);
      step();
      chk("clear_rdy_up", 32'(in_ready), 32'h1);
   endtask

   vec_t vecs[$];

   // Reference model state for the random stream
   logic          m_phase [2];
   logic [SW-1:0] m_held  [2];
   logic          m_sop   [2];
   logic          m_ov;
   logic [20:0]   m_out;

   initial begin
      logic exp_rdy;
      int   accepted;
      int   cyc;
      logic [CW-1:0] c;

      vecs.push_back(mk(1, 0, 8'h12, 1, 0, 21'h0));
      vecs.push_back(mk(1, 0, 8'h34, 0, 1, beat(0, 1, 1, 0, 16'h1234)));
      vecs.push_back(mk(1, 0, 8'hAA, 1, 0, 21'h0));
      vecs.push_back(mk(1, 1, 8'h01, 1, 0, 21'h0));
      vecs.push_back(mk(1, 0, 8'hBB, 0, 0, beat(0, 1, 0, 0, 16'hAABB)));
      vecs.push_back(mk(1, 1, 8'h02, 0, 1, beat(1, 1, 1, 0, 16'h0102)));
      vecs.push_back(mk(1, 1, 8'h55, 1, 1, beat(1, 1, 1, 1, 16'h5500)));
      vecs.push_back(mk(1, 1, 8'h66, 1, 0, 21'h0));
      vecs.push_back(mk(1, 1, 8'h77, 0, 1, beat(1, 1, 1, 0, 16'h6677)));
`ifndef DATA_FORMAT_UPSIZER_SOP_CHECK_EN
      vecs.push_back(mk(1, 0, 8'hCC, 1, 0, 21'h0));
      vecs.push_back(mk(1, 0, 8'hDD, 1, 1, beat(0, 1, 1, 0, 16'hCCDD)));
`endif
      vecs.push_back(mk(0, 0, 8'hEE, 0, 1, 21'h0));

      do_reset();

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].v, vecs[i].ch, vecs[i].d, vecs[i].sop, vecs[i].eop);
         #1;
         chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'h1);
         step();
         if (vecs[i].exp[20]) chk($sformatf("vec%0d_beat", i), 32'(obs), 32'(vecs[i].exp));
         else                 chk($sformatf("vec%0d_no_out", i), 32'(out_valid), 32'h0);
      end

      // Backpressure: pending beat must hold while the sink stalls
      drive(1, 0, 8'h11, 1, 0);
      step();
      drive(1, 0, 8'h22, 0, 1);
      step();
      out_ready = 1'b0;
      drive(1, 1, 8'h99, 1, 0);
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("bp_hold%0d", i), 32'(obs), 32'(beat(0, 1, 1, 0, 16'h1122)));
         chk($sformatf("bp_rdy%0d", i), 32'(in_ready), 32'h0);
      end
      out_ready = 1'b1;
      drive(0, 0, 8'h00, 0, 0);
      step();
      chk("bp_drained", 32'(out_valid), 32'h0);
      drive(1, 1, 8'hA1, 0, 1);
      step();
      chk("bp_no_stray_accept", 32'(obs), 32'(beat(1, 0, 1, 1, 16'hA100)));

      // Reset mid-packet: held symbol and pending beat are lost
      drive(1, 0, 8'h41, 1, 0);
      step();
      out_ready = 1'b0;
      drive(1, 1, 8'h50, 1, 1);
      step();
      chk("mid_pending", 32'(out_valid), 32'h1);
      do_reset();
      drive(1, 0, 8'h42, 0, 1);
      step();
      chk("mid_rst_lost_half", 32'(obs), 32'(beat(0, 0, 1, 1, 16'h4200)));
      drive(0, 0, 8'h00, 0, 0);
      step();

`ifdef DATA_FORMAT_UPSIZER_SOP_CHECK_EN
      do_reset();
      chk("err_after_reset", 32'(out_error), 32'h0);
      drive(1, 0, 8'h10, 1, 0);
      step();
      drive(1, 0, 8'h20, 1, 0);
      step();
      chk("err_set", 32'(out_error), 32'h1);
      chk("err_no_out", 32'(out_valid), 32'h0);
      drive(1, 0, 8'h30, 0, 1);
      step();
      chk("err_restart_beat", 32'(obs), 32'(beat(0, 1, 1, 0, 16'h2030)));
      chk("err_sticky", 32'(out_error), 32'h1);
      do_reset();
      chk("err_cleared", 32'(out_error), 32'h0);
`endif

      // Random stream against a cycle-level reference model
      do_reset();
      for (int i = 0; i < 2; i++) begin
         m_phase[i] = 1'b0; m_held[i] = '0; m_sop[i] = 1'b0;
      end
      m_ov = 1'b0;
      m_out = '0;
      accepted = 0;
      cyc = 0;
      while (accepted < 100 && cyc < 2000) begin
         c = CW'($urandom_range(0, 1));
         drive(($urandom_range(0, 3) != 0), c, SW'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`ifdef DATA_FORMAT_UPSIZER_SOP_CHECK_EN
         in_startofpacket = 1'b0;
`endif
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         exp_rdy = !m_ov || out_ready;
         chk("rand_valid", 32'(out_valid), 32'(m_ov));
         chk("rand_in_ready", 32'(in_ready), 32'(exp_rdy));
         if (m_ov && out_ready) begin
            chk("rand_beat", 32'(obs), 32'(m_out));
            m_ov = 1'b0;
         end
         if (in_valid && exp_rdy) begin
            accepted++;
            if (m_phase[c]) begin
               m_out = beat(c, m_sop[c], in_endofpacket, 1'b0, {m_held[c], in_data});
               m_ov = 1'b1;
               m_phase[c] = 1'b0;
            end else if (in_endofpacket) begin
               m_out = beat(c, in_startofpacket, 1'b1, 1'b1, {in_data, 8'h00});
               m_ov = 1'b1;
            end else begin
               m_held[c] = in_data;
               m_sop[c] = in_startofpacket;
               m_phase[c] = 1'b1;
            end
         end
         step();
         cyc++;
      end
      chk("rand_budget", 32'(accepted), 32'd100);
      drive(0, 0, 8'h00, 0, 0);
      out_ready = 1'b1;
      #1;
      chk("rand_final_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) chk("rand_final_beat", 32'(obs), 32'(m_out));
      step();
      chk("rand_drained", 32'(out_valid), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/niosii_system_data_format_upsizer.md
Name: niosII_system_data_format_upsizer

Overview:
- Avalon-ST data-format adapter, 1 symbol/beat in, 2 symbols/beat out.
- Multi-channel: interleaved channels each hold independent partial-beat state (phase, held symbol, held SOP) in an internal per-channel state store, cleared after reset.
- Sits between a narrow streaming source (e.g. 8-bit pixel/sensor stream) and a 16-bit sink in the gesture-detection datapath.

Parameters:
- SYMBOL_WIDTH, 8, bits per symbol.
- CHANNEL_WIDTH, 1, width of channel field.
- NUM_CHANNELS, 2, number of channels with state; must be ≤ 2**CHANNEL_WIDTH.

Ports:
- clk  in  1  clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  SYMBOL_WIDTH  input symbol.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_channel  in  CHANNEL_WIDTH  channel of input beat.
- in_startofpacket  in  1  SOP.
- in_endofpacket  in  1  EOP.
- out_data  out  2*SYMBOL_WIDTH  first symbol in [2*SW-1:SW], second in [SW-1:0].
- out_valid  out  1  output beat valid.
- out_ready  in  1  sink ready; transfer on out_valid && out_ready.
- out_channel  out  CHANNEL_WIDTH  channel of output beat.
- out_startofpacket  out  1  SOP.
- out_endofpacket  out  1  EOP.
- out_empty  out  1  number of empty (invalid) low symbols, 0 or 1.

Behaviour:
- Interface decided: one clock, clk; reset synchronous active-high, named reset.
- Reset values: in_ready=0, out_valid=0, out_data=0, out_channel=0, out_startofpacket=0, out_endofpacket=0, out_empty=0.
- Clear state: after reset deasserts, walk a clear counter from NUM_CHANNELS-1 down to 0, one entry per cycle. Each entry is cleared to phase=0, held=0, sop=0. in_ready stays 0 throughout, so it first asserts NUM_CHANNELS cycles after reset release.
- Ready rule (after clear): in_ready = !out_valid || out_ready. Zero-bubble; accept and output handoff may occur in the same cycle.
- Per accepted beat, indexed by in_channel; state is read combinationally, updated at the clock edge.
  - phase=0, !eop: store held=in_data, sop=in_startofpacket, phase<=1. No output.
  - phase=0, eop: emit {in_data, 0}, sop=in_sop, eop=1, empty=1. phase stays 0.
  - phase=1: emit {held, in_data}, sop=stored sop, eop=in_eop, empty=0. phase<=0.
- Output register is a single stage: latency from accepting the completing symbol to out_valid is 1 cycle. Output holds stable while out_valid && !out_ready.
- Back-to-back same-channel beats need no bypass hazard: state is updated and read in the same cycle with registered write-through. A beat accepted at cycle n sees the state written at n-1.
- in_channel ≥ NUM_CHANNELS: beat is accepted (in_ready honoured) and discarded; no state change, no output.
- SOP while phase=1 (without macro): treated as the second symbol; the held data pairs with it normally and no error is flagged.
- Reset mid-packet: all partial symbols are lost, the output beat is dropped, and the clear sequence re-runs.

Optional Feature:
DATA_FORMAT_UPSIZER_SOP_CHECK_EN
- Defined:
  - Adds port out_error (out, 1), a sticky bit cleared only by reset.
  - An accepted beat with in_startofpacket=1 on a channel with phase=1 discards the held symbol and sets out_error=1.
  - The new beat is then processed as phase=0.
- Undefined: no out_error port; behaviour as in Behaviour.

Test Plan:
- Reset, NUM_CHANNELS=2 → in_ready=0 for exactly 2 cycles after reset falls, then 1; all outputs 0 meanwhile.
- ch0: sop 0x12, then eop 0x34, out_ready=1 → one beat 1 cycle after the 2nd accept: data 0x1234, sop=1, eop=1, empty=0, channel 0.
- Interleaved ch0 0xAA(sop), ch1 0x01(sop), ch0 0xBB, ch1 0x02(eop) → ch0 0xAABB sop=1 eop=0, then ch1 0x0102 sop=1 eop=1.
- Odd packet ch1: 0x55(sop,eop) → data 0x5500, empty=1, sop=1, eop=1; ch1 phase stays 0 (next 0x66,0x77 → 0x6677).
- Backpressure: out_ready=0 for 5 cycles with an output pending → in_ready=0, out_data stable; after out_ready=1, streaming resumes with no loss or duplication over 100 random beats vs model.
- Macro defined: ch0 0x10(sop), then 0x20(sop) → out_error=1 next cycle, 0x10 discarded; then 0x30(eop) → 0x2030 sop=1. Reset clears out_error.
